// File: rtl/vco_fll_ctrl.sv
// Frequency-locked-loop controller for the ring VCO: counts synchronized VCO edges over a
// fixed clk window, binary-searches the DAC code, then tracks the target and reports lock.
module vco_fll_ctrl #(
  parameter int CODE_W        = 6,
  parameter int CNT_W         = 8,
  parameter int GATE_CYCLES   = 256,
  parameter int KICK_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_TOL      = 1,
  parameter int LOCK_HITS     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              vco_in,
  input  logic [CNT_W-1:0]  target,
  output logic [CODE_W-1:0] ctrl_code,
  output logic              vstart,
  output logic [CNT_W-1:0]  meas_count,
  output logic              busy,
  output logic              locked
);

  localparam int TMR_W = $clog2(GATE_CYCLES + KICK_CYCLES + SETTLE_CYCLES + 1);
  localparam int HIT_W = $clog2(LOCK_HITS + 1);
  localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [CODE_W-1:0] CODE_MAX = '1;
  localparam logic [CODE_W-1:0] CODE_MSB = CODE_W'(1) << (CODE_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    SETTLE,
    MEASURE,
    SAR_DECIDE,
    TRACK_DECIDE
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  edge_cnt;
  logic [HIT_W-1:0]  hit_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic              track;

  logic              sync_p0, sync_p1, sync_p2;
  logic              rise;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W:0]    cnt_plus, tgt_plus, cnt_ext, tgt_ext;
  logic              too_slow, too_fast;
  logic [HIT_W-1:0]  hits_inc;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                   input logic inc);
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic [CODE_W-1:0] code_up(input logic [CODE_W-1:0] c);
    if (c == CODE_MAX) return c;
    return c + CODE_W'(1);
  endfunction

  function automatic logic [CODE_W-1:0] code_dn(input logic [CODE_W-1:0] c);
    if (c == '0) return c;
    return c - CODE_W'(1);
  endfunction

  // Drop the current trial bit if the VCO ran fast, then try the next lower bit.
  function automatic logic [CODE_W-1:0] sar_next(input logic [CODE_W-1:0] c,
                                                 input logic [BIT_W-1:0]  b,
                                                 input logic              drop);
    logic [CODE_W-1:0] r;
    r = c;
    if (drop) r[b] = 1'b0;
    if (b != '0) r[b - BIT_W'(1)] = 1'b1;
    return r;
  endfunction

  // Stage p0/p1 resynchronize the VCO; p2 holds the previous level for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= vco_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise     = sync_p1 & ~sync_p2;
  assign cnt_next = sat_inc_cnt(edge_cnt, rise);

  // One extra bit keeps target-TOL / target+TOL from wrapping at the range ends.
  assign cnt_ext  = {1'b0, meas_count};
  assign tgt_ext  = {1'b0, target};
  assign cnt_plus = cnt_ext + (CNT_W+1)'(LOCK_TOL);
  assign tgt_plus = tgt_ext + (CNT_W+1)'(LOCK_TOL);
  assign too_slow = cnt_plus < tgt_ext;
  assign too_fast = cnt_ext > tgt_plus;
  assign hits_inc = (hit_cnt == HIT_W'(LOCK_HITS)) ? hit_cnt : hit_cnt + HIT_W'(1);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      edge_cnt   <= '0;
      hit_cnt    <= '0;
      bit_idx    <= '0;
      track      <= 1'b0;
      ctrl_code  <= '0;
      vstart     <= 1'b0;
      meas_count <= '0;
      locked     <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      timer     <= '0;
      edge_cnt  <= '0;
      hit_cnt   <= '0;
      bit_idx   <= '0;
      track     <= 1'b0;
      ctrl_code <= '0;
      vstart    <= 1'b0;
      locked    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ctrl_code <= '0;
            vstart    <= 1'b1;
            timer     <= '0;
            hit_cnt   <= '0;
            locked    <= 1'b0;
            state     <= KICK;
          end
        end
        KICK: begin
          if (timer == TMR_W'(KICK_CYCLES - 1)) begin
            vstart    <= 1'b0;
            ctrl_code <= CODE_MSB;
            bit_idx   <= BIT_W'(CODE_W - 1);
            track     <= 1'b0;
            timer     <= '0;
            state     <= SETTLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SETTLE: begin
          edge_cnt <= '0;
          if (timer == TMR_W'(SETTLE_CYCLES - 1)) begin
            timer <= '0;
            state <= MEASURE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        MEASURE: begin
          edge_cnt <= cnt_next;
          if (timer == TMR_W'(GATE_CYCLES - 1)) begin
            meas_count <= cnt_next;
            timer      <= '0;
            state      <= track ? TRACK_DECIDE : SAR_DECIDE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SAR_DECIDE: begin
          ctrl_code <= sar_next(ctrl_code, bit_idx, meas_count > target);
          if (bit_idx == '0) track <= 1'b1;
          else               bit_idx <= bit_idx - BIT_W'(1);
          state <= SETTLE;
        end
        TRACK_DECIDE: begin
          if (too_slow) begin
            ctrl_code <= code_up(ctrl_code);
            hit_cnt   <= '0;
            locked    <= 1'b0;
          end else if (too_fast) begin
            ctrl_code <= code_dn(ctrl_code);
            hit_cnt   <= '0;
            locked    <= 1'b0;
          end else begin
            hit_cnt <= hits_inc;
            if (hits_inc == HIT_W'(LOCK_HITS)) locked <= 1'b1;
          end
          state <= SETTLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vco_fll_ctrl.sv
// Bench for vco_fll_ctrl: a phase-accumulator VCO plant driven by ctrl_code, and a
// window-level model of the acquisition/tracking rules predicting every window.
module tb_vco_fll_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, start, vco;
  logic [7:0] target;
  logic [5:0] ctrl_code;
  logic       vstart, busy, locked;
  logic [7:0] meas_count;

  vco_fll_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .vco_in(vco), .target(target),
    .ctrl_code(ctrl_code), .vstart(vstart), .meas_count(meas_count), .busy(busy),
    .locked(locked)
  );

  // Second instance with a long window and a fast free-running VCO for count saturation.
  logic       en2, start2, vco2;
  logic [7:0] target2;
  logic [5:0] code2;
  logic       vstart2, busy2, locked2;
  logic [7:0] meas2;

  vco_fll_ctrl #(.GATE_CYCLES(1024)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .start(start2), .vco_in(vco2), .target(target2),
    .ctrl_code(code2), .vstart(vstart2), .meas_count(meas2), .busy(busy2),
    .locked(locked2)
  );

  initial vco2 = 1'b0;
  always #11 vco2 = ~vco2;

  int total = 0;
  int bad   = 0;

  // Plant: edges per 256-cycle window = min(128, slope*code + offset), exact in any window.
  int slope  = 0;
  int offset = 0;
  int acc    = 0;

  function automatic int plant_n(input int code);
    int n;
    n = slope * code + offset;
    if (n > 128) n = 128;
    return n;
  endfunction

  initial vco = 1'b0;
  always @(negedge clk) begin
    acc = acc + plant_n(int'(ctrl_code));
    if (acc >= 256) begin
      acc = acc - 256;
      vco = 1'b1;
    end else begin
      vco = 1'b0;
    end
  end

  // Window-level reference of the loop.
  int m_code, m_bit, m_track, m_hits, m_locked, m_meas;

  task automatic ref_start();
    m_code = 32; m_bit = 5; m_track = 0; m_hits = 0; m_locked = 0;
  endtask

  task automatic ref_window();
    int cnt, t;
    t   = int'(target);
    cnt = plant_n(m_code);
    if (cnt > 255) cnt = 255;
    m_meas = cnt;
    if (!m_track) begin
      if (cnt > t) m_code = m_code - (1 << m_bit);
      if (m_bit == 0) m_track = 1;
      else begin
        m_bit  = m_bit - 1;
        m_code = m_code + (1 << m_bit);
      end
    end else if (cnt < t - 1) begin
      if (m_code < 63) m_code = m_code + 1;
      m_hits = 0; m_locked = 0;
    end else if (cnt > t + 1) begin
      if (m_code > 0) m_code = m_code - 1;
      m_hits = 0; m_locked = 0;
    end else begin
      if (m_hits < 4) m_hits = m_hits + 1;
      if (m_hits == 4) m_locked = 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Start pulse, then vstart profile over KICK; a second start mid-KICK must be ignored.
  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("vstart_on", int'(vstart), 1);
    check("busy_on", int'(busy), 1);
    ref_start();
    for (int i = 1; i <= 16; i++) begin
      if (i == 6) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("vstart_len", int'(vstart), (i < 16) ? 1 : 0);
    end
    check("first_trial", int'(ctrl_code), 32);
  endtask

  task automatic run_windows(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (264) @(posedge clk);
      #1;
      ref_window();
      check("meas_count", int'(meas_count), m_meas);
      @(posedge clk); #1;
      check("ctrl_code", int'(ctrl_code), m_code);
      check("locked", int'(locked), m_locked);
      check("busy_run", int'(busy), 1);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);
    check("idle_code", int'(ctrl_code), 0);
    @(negedge clk);
    en = 1'b1;
  endtask

  typedef struct {
    int slope;
    int offset;
    int tgt;
    int ntrack;
    int exp_code;
    int exp_locked;
  } vec_t;

  vec_t vecs[4];
  int   held;

  initial begin
    vecs[0] = '{4, 0, 100, 4, 25, 1};
    vecs[1] = '{4, 0, 60, 4, 15, 1};
    vecs[2] = '{4, 0, 0, 4, 0, 1};
    vecs[3] = '{1, 40, 255, 3, 63, 0};

    rst_n = 1'b0; en = 1'b0; start = 1'b0; target = 8'd0;
    en2 = 1'b0; start2 = 1'b0; target2 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code", int'(ctrl_code), 0);
    check("rst_vstart", int'(vstart), 0);
    check("rst_meas", int'(meas_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_locked", int'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Table-driven acquisitions with fixed expected endpoints.
    for (int v = 0; v < 4; v++) begin
      slope  = vecs[v].slope;
      offset = vecs[v].offset;
      target = 8'(vecs[v].tgt);
      go_idle();
      run_start();
      run_windows(6 + vecs[v].ntrack);
      check("final_code", int'(ctrl_code), vecs[v].exp_code);
      check("final_locked", int'(locked), vecs[v].exp_locked);
    end

    // Disturbance after lock: plant shifts up by 8 edges.
    slope = 4; offset = 0; target = 8'd100;
    go_idle();
    run_start();
    run_windows(10);
    check("pre_dist_locked", int'(locked), 1);
    offset = 8;
    run_windows(1);
    check("dist_code1", int'(ctrl_code), 24);
    check("dist_unlock", int'(locked), 0);
    run_windows(1);
    check("dist_code2", int'(ctrl_code), 23);
    run_windows(3);
    check("relock_early", int'(locked), 0);
    run_windows(1);
    check("relock", int'(locked), 1);
    check("relock_code", int'(ctrl_code), 23);

    // Random plants and targets against the model.
    for (int r = 0; r < 3; r++) begin
      slope  = int'($urandom_range(1, 4));
      offset = int'($urandom_range(0, 40));
      target = 8'($urandom_range(0, 200));
      go_idle();
      run_start();
      run_windows(10);
    end

    // en drop in the middle of SAR.
    slope = 4; offset = 0; target = 8'd100;
    go_idle();
    run_start();
    run_windows(2);
    held = m_meas;
    repeat (100) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk); #1;
    check("en0_busy", int'(busy), 0);
    check("en0_code", int'(ctrl_code), 0);
    check("en0_vstart", int'(vstart), 0);
    check("en0_locked", int'(locked), 0);
    check("en0_meas_held", int'(meas_count), held);
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("en1_stays_idle", int'(busy), 0);

    // Asynchronous reset in the middle of MEASURE, after lock.
    run_start();
    run_windows(10);
    check("pre_rst_locked", int'(locked), 1);
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_code", int'(ctrl_code), 0);
    check("arst_vstart", int'(vstart), 0);
    check("arst_meas", int'(meas_count), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_locked", int'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_code", int'(ctrl_code), 0);

    // Edge counter saturation on the long-window instance.
    check("sat_meas_init", int'(meas2), 0);
    @(negedge clk);
    en2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (1048) @(posedge clk);
    #1;
    check("sat_meas", int'(meas2), 255);
    check("sat_busy", int'(busy2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
